// File: rtl/ingress_port.sv
// ingress_port: receive side of one switch port.
// Buffers single-beat packets in a small FIFO, decodes the destination field
// of the head packet, and raises a one-hot request to that destination's
// arbiter. On a matching grant the head packet (on data_out) is popped.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   valid_in, data_in     incoming packet (accepted when in_ready)
//   in_ready              FIFO can accept (== !full)
//   req_out               one-hot request to the destination arbiter
//   grant_in              one-hot grants from the arbiters
//   data_out              head packet, '0 when empty
//   pop_out               high in the cycle the head packet is taken
//   fifo_count/empty/full occupancy status
//
// Optional build macro INGRESS_DROP_CNT_EN adds:
//   drop_cnt [15:0]       saturating count of pushes dropped while full
//   drop_clr              clears drop_cnt (priority over increment)

package packet_pkg;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = 4;
endpackage

module ingress_port
  import packet_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DEST_LSB   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_in,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic                          in_ready,
  output logic [ADDR_WIDTH-1:0]         req_out,
  input  logic [ADDR_WIDTH-1:0]         grant_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          pop_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          empty,
  output logic                          full
`ifdef INGRESS_DROP_CNT_EN
  ,
  output logic [15:0]                   drop_cnt,
  input  logic                          drop_clr
`endif
);

  localparam int unsigned PW = $clog2(ADDR_WIDTH);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_REQUEST = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [PW-1:0]         w_dest;

  // Status; in_ready is taken from the pre-pop occupancy.
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign full       = w_full;
  assign empty      = w_empty;
  assign in_ready   = !w_full;
  assign fifo_count = r_count;

  assign w_push   = valid_in && !w_full;
  // Gated by rst_n so a reset mid-request never reports a pop.
  assign w_pop    = rst_n && !w_empty && (r_state == S_REQUEST) && ((grant_in & req_out) != '0);
  assign pop_out  = w_pop;

  assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
  assign w_dest   = data_out[DEST_LSB +: PW];

  // Next occupancy.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Next state and request decode.
  always_comb begin
    w_state_nxt = r_state;
    req_out     = '0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_REQUEST;
      end
      S_REQUEST: begin
        req_out = ADDR_WIDTH'(1) << w_dest;
        if (w_pop && (w_count_nxt == '0)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Packet storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wr_ptr] <= data_in;
  end

`ifdef INGRESS_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (drop_clr) begin
      r_drop_cnt <= '0;
    end else if (valid_in && w_full && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_ingress_port.sv
// Directed testbench for ingress_port with a queue-based scoreboard model.
module tb_ingress_port;
  import packet_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [15:0] data_in;
  logic        in_ready;
  logic [3:0]  req_out;
  logic [3:0]  grant_in;
  logic [15:0] data_out;
  logic        pop_out;
  logic [2:0]  fifo_count;
  logic        empty;
  logic        full;
`ifdef INGRESS_DROP_CNT_EN
  logic [15:0] drop_cnt;
  logic        drop_clr;
  int unsigned m_drop;
`endif

  always #5 clk = ~clk;

  ingress_port #(.FIFO_DEPTH(DEPTH), .DEST_LSB(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .in_ready   (in_ready),
    .req_out    (req_out),
    .grant_in   (grant_in),
    .data_out   (data_out),
    .pop_out    (pop_out),
    .fifo_count (fifo_count),
    .empty      (empty),
    .full       (full)
`ifdef INGRESS_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt),
    .drop_clr   (drop_clr)
`endif
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] sb [$];
  bit          m_req;
  logic        popped;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [15:0] w);
    logic [1:0] d;
    d = w[1:0];
    return 4'b0001 << d;
  endfunction

  function automatic logic [3:0] head_grant();
    logic [15:0] h;
    if (sb.size() == 0) return 4'b0000;
    h = sb[0];
    return onehot(h);
  endfunction

  // Compare all observable status against the model.
  task automatic check_state(input string tag);
    logic [15:0] head;
    head = (sb.size() > 0) ? sb[0] : 16'h0000;
    check({tag, "_count"},    32'(fifo_count), 32'(sb.size()));
    check({tag, "_empty"},    32'(empty),      32'(sb.size() == 0));
    check({tag, "_full"},     32'(full),       32'(sb.size() == DEPTH));
    check({tag, "_in_ready"}, 32'(in_ready),   32'(sb.size() != DEPTH));
    check({tag, "_data_out"}, 32'(data_out),   32'(head));
    check({tag, "_req_out"},  32'(req_out),    32'(m_req ? onehot(head) : 4'b0000));
`ifdef INGRESS_DROP_CNT_EN
    check({tag, "_drop_cnt"}, 32'(drop_cnt),   32'(m_drop));
`endif
  endtask

  // One clock cycle: drive inputs, check at negedge, update model, settle after edge.
  task automatic step(input logic v, input logic [15:0] d, input logic [3:0] g, output logic p);
    int          n_before;
    bit          exp_pop;
    bit          acc;
    logic [15:0] head;
    valid_in = v;
    data_in  = d;
    grant_in = g;
    @(negedge clk);
    n_before = sb.size();
    head     = (n_before > 0) ? sb[0] : 16'h0000;
    exp_pop  = m_req && (n_before > 0) && ((g & onehot(head)) != 4'b0000);
    acc      = v && (n_before < DEPTH);
    check_state("cyc");
    check("pop_out", 32'(pop_out), 32'(exp_pop));
    p = pop_out;
    if (pop_out && n_before > 0) check("sb_pop_data", 32'(data_out), 32'(head));
    if (exp_pop) void'(sb.pop_front());
    if (acc) sb.push_back(d);
`ifdef INGRESS_DROP_CNT_EN
    if (drop_clr) m_drop = 0;
    else if (v && n_before == DEPTH && m_drop < 32'hFFFF) m_drop++;
`endif
    if (!m_req) m_req = (n_before > 0);
    else if (exp_pop && sb.size() == 0) m_req = 1'b0;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    grant_in = 4'b0000;
`ifdef INGRESS_DROP_CNT_EN
    drop_clr = 1'b0;
`endif
    #1;
  endtask

  // One reset cycle with stimulus still active; no pop may be reported.
  task automatic apply_reset(input logic [3:0] g);
    rst_n    = 1'b0;
    grant_in = g;
    valid_in = 1'b1;
    data_in  = 16'hDEAD;
    @(negedge clk);
    check("rst_pop_out", 32'(pop_out), 32'(1'b0));
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    valid_in = 1'b0;
    grant_in = 4'b0000;
    sb.delete();
    m_req = 1'b0;
`ifdef INGRESS_DROP_CNT_EN
    m_drop = 0;
`endif
    #1;
    check_state("after_rst");
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = 16'h0000;
    grant_in = 4'b0000;
    m_req    = 1'b0;
`ifdef INGRESS_DROP_CNT_EN
    drop_clr = 1'b0;
    m_drop   = 0;
`endif
    apply_reset(4'b0000);

    // 1: single packet to dest 2, then granted.
    step(1'b1, 16'hA5A2, 4'b0000, popped);
    step(1'b0, 16'h0000, 4'b0000, popped);
    check("t1_req", 32'(req_out), 32'(4'b0100));
    check("t1_data", 32'(data_out), 32'(16'hA5A2));
    step(1'b0, 16'h0000, 4'b0100, popped);
    check("t1_pop", 32'(popped), 32'(1'b1));
    check("t1_req_after", 32'(req_out), 32'(4'b0000));
    check("t1_empty_after", 32'(empty), 32'(1'b1));

    // 2: fill to full, drop a fifth, drain in order.
    step(1'b1, 16'h1110, 4'b0000, popped);
    step(1'b1, 16'h2221, 4'b0000, popped);
    step(1'b1, 16'h3332, 4'b0000, popped);
    step(1'b1, 16'h4443, 4'b0000, popped);
    check("t2_full", 32'(full), 32'(1'b1));
    check("t2_in_ready", 32'(in_ready), 32'(1'b0));
    step(1'b1, 16'h5550, 4'b0000, popped);
    check("t2_count_after_drop", 32'(fifo_count), 32'(4));
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, head_grant(), popped);
    check("t2_drained", 32'(empty), 32'(1'b1));

    // 3: mismatched grant is ignored.
    step(1'b1, 16'h0BB1, 4'b0000, popped);
    step(1'b0, 16'h0000, 4'b0000, popped);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0000, 4'b0100, popped);
      check("t3_no_pop", 32'(popped), 32'(1'b0));
    end
    check("t3_req_held", 32'(req_out), 32'(4'b0010));
    step(1'b0, 16'h0000, 4'b0010, popped);
    check("t3_pop", 32'(popped), 32'(1'b1));

    // 4: simultaneous push and pop at count 2, then pointer wrap.
    step(1'b1, 16'h0010, 4'b0000, popped);
    step(1'b1, 16'h0021, 4'b0000, popped);
    step(1'b1, 16'h0003, head_grant(), popped);
    check("t4_count_same", 32'(fifo_count), 32'(2));
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, head_grant(), popped);
    step(1'b1, 16'hC0FF, 4'b0000, popped);
    step(1'b0, 16'h0000, 4'b0000, popped);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'hC000 | 16'(i * 17), head_grant(), popped);
      check("t4_wrap_pop", 32'(popped), 32'(1'b1));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, head_grant(), popped);
    check("t4_wrap_drained", 32'(empty), 32'(1'b1));

    // 5: reset while requesting with three packets buffered.
    step(1'b1, 16'h7771, 4'b0000, popped);
    step(1'b1, 16'h7772, 4'b0000, popped);
    step(1'b1, 16'h7773, 4'b0000, popped);
    step(1'b0, 16'h0000, 4'b0000, popped);
    apply_reset(head_grant());
    check("t5_req", 32'(req_out), 32'(4'b0000));
    check("t5_data", 32'(data_out), 32'(16'h0000));
    check("t5_count", 32'(fifo_count), 32'(0));

`ifdef INGRESS_DROP_CNT_EN
    // 6: drop counting and clear-over-increment.
    for (int i = 0; i < 4; i++) step(1'b1, 16'h9900 | 16'(i), 4'b0000, popped);
    for (int i = 0; i < 5; i++) step(1'b1, 16'hEEEE, 4'b0000, popped);
    check("t6_drop5", 32'(drop_cnt), 32'(5));
    drop_clr = 1'b1;
    step(1'b1, 16'hEEEE, 4'b0000, popped);
    check("t6_drop_clr", 32'(drop_cnt), 32'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ingress_port.md
Name: ingress_port

Overview:
- Receive side of one switch port. Accepts single-beat packets from the link, buffers them in a small FIFO, decodes the destination field of the head packet, and raises a one-hot request to the arbiter of that destination.
- On grant, the head packet is presented on data_out (it feeds data_inN of the destination output_mux) and popped.
- One instance per port; four instances per switch.

Parameters:
- FIFO_DEPTH, 4, number of buffered packets; power of 2, minimum 2.
- DEST_LSB, 0, bit position of the 2-bit destination field in the packet; destination = data_in[DEST_LSB+1:DEST_LSB].
- Package constants used: DATA_WIDTH (16) and ADDR_WIDTH (4 ports) from packet_pkg; port index width PW = $clog2(ADDR_WIDTH) = 2.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- valid_in, input, 1, incoming packet valid this cycle.
- data_in, input, DATA_WIDTH, incoming packet word.
- in_ready, output, 1, FIFO can accept; equals !full.
- req_out, output, ADDR_WIDTH, one-hot request to the destination arbiter; all-zero when idle.
- grant_in, input, ADDR_WIDTH, one-hot grant from the arbiters, one bit per destination.
- data_out, output, DATA_WIDTH, head packet; '0 when FIFO is empty.
- pop_out, output, 1, pulses high in the cycle the head packet is taken.
- fifo_count, output, $clog2(FIFO_DEPTH)+1, current occupancy.
- empty, output, 1, occupancy == 0.
- full, output, 1, occupancy == FIFO_DEPTH.

Behaviour:
- Reset (rst_n low at a clock edge):
  - Pointers and count clear to 0; FSM goes to IDLE.
  - Outputs: req_out=0, data_out=0, pop_out=0, empty=1, full=0, in_ready=1, fifo_count=0.
  - Reset mid-request discards all buffered packets; no pop_out is generated.
- Push:
  - Accepted when valid_in && !full, sampled at the clock edge; the word is written at wr_ptr, and wr_ptr wraps modulo FIFO_DEPTH.
  - valid_in while full: the word is dropped and the FIFO is unchanged. This holds even if a pop occurs in the same cycle, because in_ready is evaluated before the pop.
- Pop:
  - Occurs when state==REQUEST and (grant_in & req_out) != 0.
  - pop_out=1 combinationally in that cycle; rd_ptr advances at the edge and wraps modulo FIFO_DEPTH.
  - Grant bits not matching req_out are ignored: no pop, request held.
- Simultaneous push and pop with the FIFO not full: both occur and count is unchanged.
- Count: +1 on push-only, -1 on pop-only, unchanged on both or neither. It never exceeds FIFO_DEPTH or goes below 0.
- data_out = mem[rd_ptr] when !empty, else 0. It is combinational from registered state and stable while the request is held.
- FSM, 2 states, registered:
  - IDLE: req_out=0. When !empty, go to REQUEST next cycle.
  - REQUEST: req_out = one-hot(decode of data_out[DEST_LSB+1:DEST_LSB]). On pop: if count after the pop > 0, stay in REQUEST with the new head's destination; else go to IDLE.
  - Without a pop, stay in REQUEST and hold req_out constant; the request is never withdrawn.
- Latency:
  - Push into an empty FIFO at edge N gives req_out valid from edge N+1, one cycle of IDLE→REQUEST.
  - Back-to-back grants give one pop per cycle; throughput is 1 packet/cycle.
- Destination equal to the own port index is routed normally; no filtering.

Optional Feature:
- Macro: INGRESS_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt [15:0], cleared at reset.
  - Increments by 1 each cycle with valid_in && full, and saturates at 16'hFFFF (no wrap).
  - Adds input drop_clr [1]: clears drop_cnt to 0 next edge; clear has priority over increment.
- When undefined: neither port exists, no counter logic, and drops are silent.

Test Plan:
1. Reset, then push data_in=16'hA5A2 (dest 2) with grant_in=0 → next cycle req_out=4'b0100, data_out=16'hA5A2, count=1. Assert grant_in=4'b0100 → pop_out=1 in that cycle; next cycle req_out=0, empty=1.
2. Push 4 words with dest 0,1,2,3 with no grant → full=1, in_ready=0, count=4; a 5th push is dropped. Then grant each cycle matching req_out → req_out sequence 0001, 0010, 0100, 1000, then 0; data_out order preserved.
3. Head dest 1 (req_out=4'b0010), drive grant_in=4'b0100 for 3 cycles → no pop_out, req_out and data_out unchanged; then grant_in=4'b0010 → pop.
4. Count=2, same-cycle push of 16'h0003 and matching grant → count stays 2, and the new word appears at the tail in order. Cover pointer wrap by running 10 push/pop pairs through depth 4 with data integrity checked.
5. Count=3 in REQUEST, rst_n=0 for one cycle → next cycle count=0, req_out=0, data_out=0, and no pop_out.
6. (INGRESS_DROP_CNT_EN) Fill the FIFO, drive valid_in for 5 extra cycles → drop_cnt=5. Pulse drop_clr concurrently with a drop → drop_cnt=0.
